myled_axil_arbiter: RTL and testbench

MYLED_AXIL_ARBITER -- requirements
Module: myled_axil_arbiter

---
 rtl/myled_axil_pkg.sv | 28 ++
 rtl/myled_rr_arb.sv | 39 +++
 rtl/myled_axil_arbiter.sv | 167 ++++++++++++++++
 tb/tb_myled_axil_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myled_axil_pkg.sv
// rtl/myled_axil_pkg.sv - shared types and constants for the myLed AXI4-Lite arbiter
// Contents: FSM state enum, AXI response codes, myLed register offsets,
// fixed AXI sideband values.
package myled_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WB,
    ST_RA,
    ST_RD,
    ST_RSP
  } axil_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] REG0_OFFSET = 4'h0;
  localparam logic [3:0] REG1_OFFSET = 4'h4;
  localparam logic [3:0] REG2_OFFSET = 4'h8;
  localparam logic [3:0] REG3_OFFSET = 4'hC;

  localparam logic [2:0] AXI_PROT  = 3'b000;
  localparam logic [3:0] WSTRB_ALL = 4'hF;

endpackage

// File: rtl/myled_rr_arb.sv
// rtl/myled_rr_arb.sv - two-way round-robin grant with last-grant memory
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req[1:0]   : request vector
//   take       : grant is consumed this cycle; remember it as last grant
//   grant_idx  : index of the requester that wins this cycle
module myled_rr_arb
  import myled_axil_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant_idx
);

  logic last_q;

  // Under contention the requester not granted last wins; a lone requester
  // is granted directly regardless of history.
  always_comb begin
    grant_idx = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_q;
      default: grant_idx = 1'b0;
    endcase
  end

  // Resetting to 1 makes requester 0 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/myled_axil_arbiter.sv
// rtl/myled_axil_arbiter.sv - two-requester arbiter onto one AXI4-Lite master port
// Ports:
//   ACLK, ARESET              : clock, synchronous active-high reset
//   req_valid/ready/write     : per-requester request handshake and direction
//   req_addr/req_wdata        : per-requester address/data slices
//   rsp_valid/rsp_rdata/resp  : one-hot completion pulse with shared data/resp
//   M_AXI_*                   : AXI4-Lite master (AW, W, B, AR, R channels)
module myled_axil_arbiter
  import myled_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  axil_state_t           state_q, state_d;
  logic                  gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  aw_done_q, w_done_q;
  logic                  grant_idx;
  logic                  take;

  myled_rr_arb u_arb (
    .clk       (ACLK),
    .rst       (ARESET),
    .req       (req_valid),
    .take      (take),
    .grant_idx (grant_idx)
  );

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_AWPROT = AXI_PROT;
  assign M_AXI_ARPROT = AXI_PROT;
  assign M_AXI_WSTRB  = WSTRB_ALL;

  always_comb begin
    state_d       = state_q;
    take          = 1'b0;
    req_ready     = 2'b00;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 2'b00;
    rsp_rdata     = '0;
    rsp_resp      = RESP_OKAY;
    case (state_q)
      ST_IDLE: begin
        // Gate on ARESET so nothing is accepted in a reset cycle.
        if ((|req_valid) && !ARESET) begin
          take      = 1'b1;
          req_ready = grant_idx ? 2'b10 : 2'b01;
          state_d   = req_write[grant_idx] ? ST_WR : ST_RA;
        end
      end
      ST_WR: begin
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        // While a channel is still pending its VALID is high, so READY
        // alone marks the handshake.
        if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY)) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_d = ST_RSP;
      end
      ST_RA: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = ST_RD;
      end
      ST_RD: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_d = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        rsp_rdata = rdata_q;
        rsp_resp  = resp_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            gnt_q     <= grant_idx;
            addr_q    <= grant_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0];
            wdata_q   <= grant_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                   : req_wdata[DATA_WIDTH-1:0];
            // Writes report zero read data.
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end
        end
        ST_WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_q <= 1'b1;
          if (M_AXI_WVALID && M_AXI_WREADY)   w_done_q  <= 1'b1;
        end
        ST_WB: begin
          if (M_AXI_BVALID) resp_q <= M_AXI_BRESP;
        end
        ST_RD: begin
          if (M_AXI_RVALID) begin
            rdata_q <= M_AXI_RDATA;
            resp_q  <= M_AXI_RRESP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myled_axil_arbiter.sv
// tb/tb_myled_axil_arbiter.sv - directed self-checking bench for myled_axil_arbiter
module tb_myled_axil_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = 2'b00;
  logic [7:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;
  logic [3:0]  M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY = 1'b0;
  logic [31:0] M_AXI_RDATA = '0;
  logic [1:0]  M_AXI_RRESP = 2'b00;
  logic        M_AXI_RVALID = 1'b0;
  logic        M_AXI_RREADY;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  myled_axil_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Slave model knobs, written only by the test sequence.
  int          aw_lat = 0;
  int          w_lat = 0;
  bit          b_hold = 1'b0;
  bit          err_c = 1'b0;
  logic [31:0] err_data = '0;

  // Slave model state, written only by the slave process.
  logic [31:0] mem [4] = '{default: 32'h0};
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit          aw_seen = 0, w_seen = 0, rd_pend = 0, b_hs = 0, r_hs = 0;
  logic [3:0]  aw_a = '0, ar_a = '0;
  logic [31:0] w_d = '0;

  // Slave acts on the falling edge; a VALID&READY seen here completes on the next rising edge.
  always @(negedge ACLK) begin
    if (ARESET) begin
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
      M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0; rd_pend = 0; b_hs = 0; r_hs = 0;
    end else begin
      if (b_hs) begin M_AXI_BVALID = 0; b_hs = 0; end
      if (r_hs) begin M_AXI_RVALID = 0; r_hs = 0; end
      if (aw_seen && w_seen && !M_AXI_BVALID && !b_hold) begin
        mem[aw_a[3:2]] = w_d;
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        aw_seen = 0; w_seen = 0;
      end
      if (rd_pend && !M_AXI_RVALID) begin
        M_AXI_RVALID = 1;
        if (err_c && ar_a == 4'hC) begin M_AXI_RDATA = err_data; M_AXI_RRESP = 2'b10; end
        else begin M_AXI_RDATA = mem[ar_a[3:2]]; M_AXI_RRESP = 2'b00; end
        rd_pend = 0;
      end
      if (!M_AXI_AWVALID) begin M_AXI_AWREADY = 0; aw_cnt = 0; end
      else if (aw_cnt >= aw_lat) M_AXI_AWREADY = 1;
      else begin M_AXI_AWREADY = 0; aw_cnt++; end
      if (!M_AXI_WVALID) begin M_AXI_WREADY = 0; w_cnt = 0; end
      else if (w_cnt >= w_lat) M_AXI_WREADY = 1;
      else begin M_AXI_WREADY = 0; w_cnt++; end
      M_AXI_ARREADY = M_AXI_ARVALID;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_seen = 1; aw_a = M_AXI_AWADDR; end
      if (M_AXI_WVALID && M_AXI_WREADY) begin w_seen = 1; w_d = M_AXI_WDATA; end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin rd_pend = 1; ar_a = M_AXI_ARADDR; end
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs = 1; b_cnt++; end
      if (M_AXI_RVALID && M_AXI_RREADY) r_hs = 1;
    end
  end

  // Observation counters.
  int gq[$];
  int dual = 0, aw_hi = 0, w_hi = 0;
  int rsp_cnt [2] = '{0, 0};

  always @(negedge ACLK) begin
    if (req_ready == 2'b11) dual++;
    if (req_ready[0]) gq.push_back(0);
    else if (req_ready[1]) gq.push_back(1);
    if (M_AXI_AWVALID) aw_hi++;
    if (M_AXI_WVALID) w_hi++;
    if (rsp_valid[0]) rsp_cnt[0]++;
    if (rsp_valid[1]) rsp_cnt[1]++;
  end

  // Present a request and wait for its accept; returns just after the grant edge.
  task automatic issue(input int r, input logic wr, input logic [3:0] a,
                       input logic [31:0] d, output bit ok);
    ok = 0;
    req_write[r] = wr;
    req_addr[r*4 +: 4] = a;
    req_wdata[r*32 +: 32] = d;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge ACLK);
      if (req_ready[r]) ok = 1;
      @(posedge ACLK); #1;
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, output logic [31:0] rd, output logic [1:0] rs,
                          output bit ok);
    ok = 0; rd = '0; rs = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge ACLK);
      if (rsp_valid[r]) begin ok = 1; rd = rsp_rdata; rs = rsp_resp; end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h04;
    repeat (2) begin
      @(negedge ACLK);
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_no_accept: req_ready=%b expected 00", req_ready); end
    end
    @(posedge ACLK); #1;
    req_valid = 2'b00; ARESET = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b0) begin
      errors++; $display("FAIL reset_axi: aw/w/ar/b/r=%b expected 00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
    end
    checks++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL reset_rsp: valid=%b rdata=%h resp=%b expected 00/0/00", rsp_valid, rsp_rdata, rsp_resp);
    end
    checks++;
    if (M_AXI_AWADDR !== 4'h0 || M_AXI_WDATA !== 32'h0) begin
      errors++; $display("FAIL reset_capture: awaddr=%h wdata=%h expected 0/0", M_AXI_AWADDR, M_AXI_WDATA);
    end
    checks++;
    if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000 || M_AXI_WSTRB !== 4'hF) begin
      errors++; $display("FAIL fixed_sideband: awprot=%b arprot=%b wstrb=%h expected 000/000/f",
        M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_write_read();
    bit ok; logic [31:0] rd; logic [1:0] rs;
    issue(0, 1'b1, 4'h4, 32'h0000_00A5, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_grant: got no req_ready[0] expected one"); end
    checks++;
    if (M_AXI_AWVALID !== 1'b1 || M_AXI_WVALID !== 1'b1) begin
      errors++; $display("FAIL wr_latency: awvalid=%b wvalid=%b expected 1/1", M_AXI_AWVALID, M_AXI_WVALID);
    end
    checks++;
    if (M_AXI_AWADDR !== 4'h4 || M_AXI_WDATA !== 32'hA5) begin
      errors++; $display("FAIL wr_fields: awaddr=%h wdata=%h expected 4/a5", M_AXI_AWADDR, M_AXI_WDATA);
    end
    wait_rsp(0, rd, rs, ok);
    checks++;
    if (!ok || rs !== 2'b00 || rd !== 32'h0) begin
      errors++; $display("FAIL wr_rsp: seen=%0d resp=%b rdata=%h expected 1/00/0", ok, rs, rd);
    end
    checks++;
    if (mem[1] !== 32'hA5) begin errors++; $display("FAIL wr_mem: mem1=%h expected a5", mem[1]); end
    issue(1, 1'b0, 4'h4, 32'h0, ok);
    checks++;
    if (!ok || M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 4'h4) begin
      errors++; $display("FAIL rd_issue: granted=%0d arvalid=%b araddr=%h expected 1/1/4", ok, M_AXI_ARVALID, M_AXI_ARADDR);
    end
    wait_rsp(1, rd, rs, ok);
    checks++;
    if (!ok || rd !== 32'hA5 || rs !== 2'b00) begin
      errors++; $display("FAIL rd_rsp: seen=%0d rdata=%h resp=%b expected 1/a5/00", ok, rd, rs);
    end
  endtask

  task automatic test_round_robin();
    int base, d0, r0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    base = gq.size(); d0 = dual; r0 = rsp_cnt[0] + rsp_cnt[1];
    req_write = 2'b00; req_addr = 8'h44; req_valid = 2'b11;
    for (int i = 0; i < 200 && gq.size() < base + 4; i++) begin
      @(posedge ACLK); #1;
    end
    req_valid = 2'b00;
    repeat (10) begin @(posedge ACLK); #1; end
    checks++;
    if (gq.size() - base !== 4) begin errors++; $display("FAIL rr_count: grants=%0d expected 4", gq.size() - base); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gq.size() <= base + k) begin
        errors++; $display("FAIL rr_order%0d: got no grant expected %0d", k, k % 2);
      end else if (gq[base + k] != k % 2) begin
        errors++; $display("FAIL rr_order%0d: got %0d expected %0d", k, gq[base + k], k % 2);
      end
    end
    checks++;
    if (dual != d0) begin errors++; $display("FAIL rr_onehot: double ready cycles=%0d expected 0", dual - d0); end
    checks++;
    if (rsp_cnt[0] + rsp_cnt[1] - r0 != 4) begin
      errors++; $display("FAIL rr_rsp: responses=%0d expected 4", rsp_cnt[0] + rsp_cnt[1] - r0);
    end
  endtask

  task automatic test_wready_delay();
    bit ok; logic [31:0] rd; logic [1:0] rs;
    int a0, w0, b0, r0;
    w_lat = 3;
    a0 = aw_hi; w0 = w_hi; b0 = b_cnt; r0 = rsp_cnt[0];
    issue(0, 1'b1, 4'h8, 32'h0000_0055, ok);
    wait_rsp(0, rd, rs, ok);
    repeat (3) begin @(posedge ACLK); #1; end
    w_lat = 0;
    checks++;
    if (!ok || rs !== 2'b00) begin errors++; $display("FAIL wdly_rsp: seen=%0d resp=%b expected 1/00", ok, rs); end
    checks++;
    if (aw_hi - a0 != 1) begin errors++; $display("FAIL wdly_aw_cycles: got %0d expected 1", aw_hi - a0); end
    checks++;
    if (w_hi - w0 != 4) begin errors++; $display("FAIL wdly_w_cycles: got %0d expected 4", w_hi - w0); end
    checks++;
    if (b_cnt - b0 != 1) begin errors++; $display("FAIL wdly_b_count: got %0d expected 1", b_cnt - b0); end
    checks++;
    if (rsp_cnt[0] - r0 != 1) begin errors++; $display("FAIL wdly_rsp_count: got %0d expected 1", rsp_cnt[0] - r0); end
  endtask

  task automatic test_slverr();
    bit ok; logic [31:0] rd; logic [1:0] rs;
    err_c = 1'b1; err_data = 32'h0BAD_F00D;
    issue(1, 1'b0, 4'hC, 32'h0, ok);
    wait_rsp(1, rd, rs, ok);
    err_c = 1'b0;
    checks++;
    if (!ok || rs !== 2'b10) begin errors++; $display("FAIL slverr_resp: seen=%0d resp=%b expected 1/10", ok, rs); end
    checks++;
    if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL slverr_data: rdata=%h expected 0badf00d", rd); end
    issue(0, 1'b1, 4'h0, 32'h7, ok);
    wait_rsp(0, rd, rs, ok);
    checks++;
    if (!ok || rd !== 32'h0 || rs !== 2'b00) begin
      errors++; $display("FAIL write_after_read: seen=%0d rdata=%h resp=%b expected 1/0/00", ok, rd, rs);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen; logic [31:0] rd; logic [1:0] rs; int r0;
    b_hold = 1'b1;
    issue(0, 1'b1, 4'h8, 32'h33, ok);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (M_AXI_BREADY) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_reach_wb: bready never seen expected 1"); end
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    r0 = rsp_cnt[0];
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, req_ready, rsp_valid} !== 9'b0) begin
      errors++; $display("FAIL mid_outputs: handshakes=%b expected 0",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, req_ready, rsp_valid});
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00 || M_AXI_AWADDR !== 4'h0 || M_AXI_WDATA !== 32'h0) begin
      errors++; $display("FAIL mid_regs: rdata=%h resp=%b awaddr=%h wdata=%h expected zeros",
        rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_WDATA);
    end
    repeat (5) begin @(posedge ACLK); #1; end
    checks++;
    if (rsp_cnt[0] != r0) begin errors++; $display("FAIL mid_no_rsp: responses=%0d expected 0", rsp_cnt[0] - r0); end
    b_hold = 1'b0;
    issue(0, 1'b1, 4'h0, 32'h1, ok);
    wait_rsp(0, rd, rs, ok);
    checks++;
    if (!ok || rs !== 2'b00 || mem[0] !== 32'h1) begin
      errors++; $display("FAIL mid_recover: seen=%0d resp=%b mem0=%h expected 1/00/1", ok, rs, mem[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [31:0] rd; logic [1:0] rs; logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      issue(0, 1'b1, a, 32'(i + 1), ok);
      wait_rsp(0, rd, rs, ok);
      checks++;
      if (!ok || rs !== 2'b00) begin errors++; $display("FAIL b2b_wr%0d: seen=%0d resp=%b expected 1/00", i, ok, rs); end
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      issue(1, 1'b0, a, 32'h0, ok);
      wait_rsp(1, rd, rs, ok);
      checks++;
      if (!ok || rd !== 32'(i + 1) || rs !== 2'b00) begin
        errors++; $display("FAIL b2b_rd%0d: seen=%0d rdata=%h resp=%b expected 1/%h/00", i, ok, rd, rs, 32'(i + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_wready_delay();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 expected finish");
    $fatal(1, "watchdog");
  end

endmodule
